// File: rtl/chs_power_sequencer_if.sv
// Bundle of signals between the mode/power decode (master) and the
// power sequencer (slave). The decode side posts targets and watches
// the actuator state.
interface chs_power_sequencer_if;
  logic       cfg_valid;
  logic [3:0] cfg_power;
  logic       cfg_mode;
  logic [3:0] act_power;
  logic       act_mode;
  logic       busy;
  logic       settled;

  modport master (
    output cfg_valid, cfg_power, cfg_mode,
    input  act_power, act_mode, busy, settled
  );

  modport slave (
    input  cfg_valid, cfg_power, cfg_mode,
    output act_power, act_mode, busy, settled
  );
endinterface

// File: rtl/chs_power_sequencer.sv
// Power sequencer for the cooler/heater actuator. It latches the requested
// target, then walks the actuator power one step at a time at a fixed
// rate. A heat/cool flip first ramps power down to zero and holds a dead
// time before the mode is flipped and the power ramps back up.
module chs_power_sequencer #(
  parameter int RAMP_DIV    = 4,
  parameter int DEAD_CYCLES = 8,
  parameter int MAX_POWER   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  chs_power_sequencer_if.slave    bus
);

  localparam int DIV_W  = (RAMP_DIV > 1)    ? $clog2(RAMP_DIV)    : 1;
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [3:0]        MAX_P     = 4'(MAX_POWER);

  typedef enum logic [1:0] {
    HOLD,
    RAMP,
    DEAD
  } state_t;

  state_t            state, state_n;
  logic [3:0]        act_power, act_power_n;
  logic              act_mode, act_mode_n;
  logic [3:0]        tgt_power;
  logic              tgt_mode;
  logic [DIV_W-1:0]  div_cnt, div_cnt_n;
  logic [DEAD_W-1:0] dead_cnt, dead_cnt_n;
  logic              settled, settled_n;

  logic              mode_diff;
  logic [3:0]        goal;

  // While a mode flip is pending the power has to come down to zero first.
  assign mode_diff = (tgt_mode != act_mode);
  assign goal      = mode_diff ? 4'd0 : tgt_power;

  // Target register: last cfg write wins, power saturated at MAX_POWER.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_power <= 4'd0;
      tgt_mode  <= 1'b0;
    end else if (bus.cfg_valid) begin
      tgt_power <= (bus.cfg_power > MAX_P) ? MAX_P : bus.cfg_power;
      tgt_mode  <= bus.cfg_mode;
    end
  end

  // Sequencer state, actuator outputs and the step/dead-time counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      act_power <= 4'd0;
      act_mode  <= 1'b0;
      div_cnt   <= '0;
      dead_cnt  <= '0;
      settled   <= 1'b0;
    end else begin
      state     <= state_n;
      act_power <= act_power_n;
      act_mode  <= act_mode_n;
      div_cnt   <= div_cnt_n;
      dead_cnt  <= dead_cnt_n;
      settled   <= settled_n;
    end
  end

  // Next-state logic: step toward goal in RAMP, count out the dead time
  // in DEAD, and leave DEAD early if the flip request is withdrawn.
  always_comb begin
    state_n     = state;
    act_power_n = act_power;
    act_mode_n  = act_mode;
    div_cnt_n   = div_cnt;
    dead_cnt_n  = dead_cnt;
    settled_n   = 1'b0;

    case (state)
      HOLD: begin
        if (act_power != goal) begin
          state_n   = RAMP;
          div_cnt_n = '0;
        end else if (mode_diff) begin
          state_n    = DEAD;
          dead_cnt_n = '0;
        end
      end

      RAMP: begin
        if (act_power == goal) begin
          if (!mode_diff) begin
            state_n   = HOLD;
            settled_n = 1'b1;
          end else begin
            state_n    = DEAD;
            dead_cnt_n = '0;
          end
        end else if (div_cnt == DIV_LAST) begin
          div_cnt_n   = '0;
          act_power_n = (goal > act_power) ? act_power + 4'd1
                                           : act_power - 4'd1;
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end

      DEAD: begin
        if (!mode_diff) begin
          if (tgt_power != 4'd0) begin
            state_n   = RAMP;
            div_cnt_n = '0;
          end else begin
            state_n   = HOLD;
            settled_n = 1'b1;
          end
        end else if (dead_cnt == DEAD_LAST) begin
          act_mode_n = tgt_mode;
          if (tgt_power != 4'd0) begin
            state_n   = RAMP;
            div_cnt_n = '0;
          end else begin
            state_n   = HOLD;
            settled_n = 1'b1;
          end
        end else begin
          dead_cnt_n = dead_cnt + 1'b1;
        end
      end

      default: begin
        state_n = HOLD;
      end
    endcase
  end

  assign bus.act_power = act_power;
  assign bus.act_mode  = act_mode;
  assign bus.busy      = (state != HOLD);
  assign bus.settled   = settled;

endmodule

// File: tb/tb_chs_power_sequencer.sv
// Testbench for chs_power_sequencer: a timestamp-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_chs_power_sequencer;

  localparam int RAMP_DIV    = 4;
  localparam int DEAD_CYCLES = 8;
  localparam int MAX_POWER   = 8;

  localparam int PH_IDLE = 0;
  localparam int PH_RAMP = 1;
  localparam int PH_WAIT = 2;

  logic clk;
  logic rst;

  chs_power_sequencer_if bus();

  chs_power_sequencer #(
    .RAMP_DIV   (RAMP_DIV),
    .DEAD_CYCLES(DEAD_CYCLES),
    .MAX_POWER  (MAX_POWER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int e_off  = 0;

  // Reference model state: absolute cycle stamps instead of counters.
  int cyc = 0;
  int m_pow = 0, m_mode = 0, m_tp = 0, m_tm = 0;
  int m_phase = PH_IDLE;
  int m_next = 0, m_flip = 0;
  int m_goal = 0;
  bit m_settled = 1'b0;
  bit model_on = 1'b0;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: applies the sequencing rules at each rising edge using
  // the pre-edge target, then captures any new cfg write.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_pow = 0; m_mode = 0; m_tp = 0; m_tm = 0;
      m_phase = PH_IDLE; m_settled = 1'b0;
      model_on = 1'b1;
    end else begin
      m_goal = (m_tm != m_mode) ? 0 : m_tp;
      m_settled = 1'b0;
      case (m_phase)
        PH_IDLE: begin
          if (m_pow != m_goal) begin
            m_phase = PH_RAMP; m_next = cyc + RAMP_DIV;
          end else if (m_tm != m_mode) begin
            m_phase = PH_WAIT; m_flip = cyc + DEAD_CYCLES;
          end
        end
        PH_RAMP: begin
          if (m_pow == m_goal) begin
            if (m_tm == m_mode) begin
              m_phase = PH_IDLE; m_settled = 1'b1;
            end else begin
              m_phase = PH_WAIT; m_flip = cyc + DEAD_CYCLES;
            end
          end else if (cyc == m_next) begin
            m_pow  = (m_goal > m_pow) ? m_pow + 1 : m_pow - 1;
            m_next = cyc + RAMP_DIV;
          end
        end
        default: begin
          if (m_tm == m_mode || cyc == m_flip) begin
            m_mode = m_tm;
            if (m_tp != 0) begin
              m_phase = PH_RAMP; m_next = cyc + RAMP_DIV;
            end else begin
              m_phase = PH_IDLE; m_settled = 1'b1;
            end
          end
        end
      endcase
      if (bus.cfg_valid) begin
        m_tp = (int'(bus.cfg_power) > MAX_POWER) ? MAX_POWER : int'(bus.cfg_power);
        m_tm = int'(bus.cfg_mode);
      end
    end
  end

  // Compare process: every cycle, mid-period, DUT against the model.
  always @(negedge clk) begin
    if (model_on) begin
      checks += 5;
      if (int'(bus.act_power) != m_pow) begin
        errors++;
        $display("[TB] FAIL model_act_power cyc=%0d: got %0d expected %0d", cyc, bus.act_power, m_pow);
      end
      if (int'(bus.act_mode) != m_mode) begin
        errors++;
        $display("[TB] FAIL model_act_mode cyc=%0d: got %0d expected %0d", cyc, bus.act_mode, m_mode);
      end
      if (bus.busy != (m_phase != PH_IDLE)) begin
        errors++;
        $display("[TB] FAIL model_busy cyc=%0d: got %0d expected %0d", cyc, bus.busy, m_phase != PH_IDLE);
      end
      if (bus.settled != m_settled) begin
        errors++;
        $display("[TB] FAIL model_settled cyc=%0d: got %0d expected %0d", cyc, bus.settled, m_settled);
      end
      if (int'(bus.act_power) > MAX_POWER) begin
        errors++;
        $display("[TB] FAIL power_limit cyc=%0d: got %0d expected <= %0d", cyc, bus.act_power, MAX_POWER);
      end
    end
  end

  // Literal comparison helper.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Write a target; it is captured on the next rising edge.
  task automatic applyStimulus(input int pwr, input int mode);
    bus.cfg_valid = 1'b1;
    bus.cfg_power = 4'(pwr);
    bus.cfg_mode  = mode[0];
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    e_off++;
  endtask

  // Advance to just after edge E+n of the current scenario.
  task automatic atEdge(input int n);
    while (e_off < n) begin
      @(posedge clk);
      e_off++;
    end
    #1;
  endtask

  // Bounded wait for the settled pulse.
  task automatic waitSettled(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = bus.settled;
    end
    checkOutput(name, int'(seen), 1);
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    rst = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_power = 4'd5;
    bus.cfg_mode  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_power",   int'(bus.act_power), 0);
    checkOutput("reset_mode",    int'(bus.act_mode), 0);
    checkOutput("reset_busy",    int'(bus.busy), 0);
    checkOutput("reset_settled", int'(bus.settled), 0);
    rst = 1'b0;
    bus.cfg_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post_reset_power", int'(bus.act_power), 0);
    checkOutput("post_reset_busy",  int'(bus.busy), 0);

    // Ramp up 0 -> 3, cool.
    e_off = -1; applyStimulus(3, 0);
    checkOutput("ru_busy_E0", int'(bus.busy), 0);
    atEdge(1);  checkOutput("ru_busy_E1", int'(bus.busy), 1);
    atEdge(4);  checkOutput("ru_pow_E4", int'(bus.act_power), 0);
    atEdge(5);  checkOutput("ru_pow_E5", int'(bus.act_power), 1);
    atEdge(9);  checkOutput("ru_pow_E9", int'(bus.act_power), 2);
    atEdge(13); checkOutput("ru_pow_E13", int'(bus.act_power), 3);
                checkOutput("ru_settled_E13", int'(bus.settled), 0);
    atEdge(14); checkOutput("ru_settled_E14", int'(bus.settled), 1);
                checkOutput("ru_busy_E14", int'(bus.busy), 0);
    atEdge(15); checkOutput("ru_settled_E15", int'(bus.settled), 0);

    // Mode change 3/cool -> 2/heat.
    e_off = -1; applyStimulus(2, 1);
    atEdge(5);  checkOutput("mc_pow_E5", int'(bus.act_power), 2);
    atEdge(9);  checkOutput("mc_pow_E9", int'(bus.act_power), 1);
    atEdge(13); checkOutput("mc_pow_E13", int'(bus.act_power), 0);
    atEdge(14); checkOutput("mc_busy_E14", int'(bus.busy), 1);
    atEdge(21); checkOutput("mc_mode_E21", int'(bus.act_mode), 0);
    atEdge(22); checkOutput("mc_mode_E22", int'(bus.act_mode), 1);
                checkOutput("mc_pow_E22", int'(bus.act_power), 0);
    atEdge(26); checkOutput("mc_pow_E26", int'(bus.act_power), 1);
    atEdge(30); checkOutput("mc_pow_E30", int'(bus.act_power), 2);
    atEdge(31); checkOutput("mc_settled_E31", int'(bus.settled), 1);
                checkOutput("mc_busy_E31", int'(bus.busy), 0);

    // Back to 3/cool, then a flip request withdrawn during dead time.
    applyStimulus(3, 0);
    waitSettled("back_to_cool_settled");
    checkOutput("back_to_cool_pow", int'(bus.act_power), 3);
    e_off = -1; applyStimulus(2, 1);
    atEdge(13); checkOutput("ab_pow_E13", int'(bus.act_power), 0);
    atEdge(14); checkOutput("ab_busy_E14", int'(bus.busy), 1);
    atEdge(15); applyStimulus(2, 0);
    atEdge(17); checkOutput("ab_mode_E17", int'(bus.act_mode), 0);
                checkOutput("ab_busy_E17", int'(bus.busy), 1);
    atEdge(20); checkOutput("ab_pow_E20", int'(bus.act_power), 0);
    atEdge(21); checkOutput("ab_pow_E21", int'(bus.act_power), 1);
    atEdge(25); checkOutput("ab_pow_E25", int'(bus.act_power), 2);
    atEdge(26); checkOutput("ab_settled_E26", int'(bus.settled), 1);
                checkOutput("ab_mode_E26", int'(bus.act_mode), 0);

    // Clamp: request 12 saturates at 8.
    applyStimulus(0, 0);
    waitSettled("to_zero_settled");
    e_off = -1; applyStimulus(12, 0);
    atEdge(32); checkOutput("cl_pow_E32", int'(bus.act_power), 7);
    atEdge(33); checkOutput("cl_pow_E33", int'(bus.act_power), 8);
    atEdge(34); checkOutput("cl_settled_E34", int'(bus.settled), 1);
    atEdge(40); checkOutput("cl_pow_E40", int'(bus.act_power), 8);
                checkOutput("cl_busy_E40", int'(bus.busy), 0);

    // Reversal: retarget on the same edge as the step to 5.
    applyStimulus(0, 0);
    waitSettled("to_zero_settled2");
    e_off = -1; applyStimulus(8, 0);
    atEdge(20); checkOutput("rv_pow_E20", int'(bus.act_power), 4);
    applyStimulus(2, 0);
    checkOutput("rv_pow_E21", int'(bus.act_power), 5);
    atEdge(24); checkOutput("rv_pow_E24", int'(bus.act_power), 5);
    atEdge(25); checkOutput("rv_pow_E25", int'(bus.act_power), 4);
    atEdge(29); checkOutput("rv_pow_E29", int'(bus.act_power), 3);
    atEdge(33); checkOutput("rv_pow_E33", int'(bus.act_power), 2);
    atEdge(34); checkOutput("rv_settled_E34", int'(bus.settled), 1);

    // Rewriting the current target in HOLD is a no-op.
    e_off = -1; applyStimulus(2, 0);
    atEdge(1); checkOutput("nop_busy_E1", int'(bus.busy), 0);
               checkOutput("nop_settled_E1", int'(bus.settled), 0);
    atEdge(3); checkOutput("nop_busy_E3", int'(bus.busy), 0);

    // Reset in the middle of a ramp.
    e_off = -1; applyStimulus(8, 0);
    atEdge(13); checkOutput("rm_pow_E13", int'(bus.act_power), 5);
                checkOutput("rm_busy_E13", int'(bus.busy), 1);
    rst = 1'b1;
    atEdge(14); checkOutput("rm_pow_E14", int'(bus.act_power), 0);
                checkOutput("rm_busy_E14", int'(bus.busy), 0);
                checkOutput("rm_settled_E14", int'(bus.settled), 0);
                checkOutput("rm_mode_E14", int'(bus.act_mode), 0);
    rst = 1'b0;
    atEdge(24); checkOutput("rm_pow_E24", int'(bus.act_power), 0);
                checkOutput("rm_busy_E24", int'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/chs_power_sequencer.md
Name: chs_power_sequencer

Overview:
- Sequencer between the mode/power decode (popcount power 0..8, heat=1/cool=0 mode) and the cooler/heater actuator.
- Latches the requested target, then ramps actuator power one step at a time at a programmable rate.
- A mode change (heat<->cool) ramps power down to 0, holds a dead time, flips the mode, then ramps up to the new target.

Parameters:
- RAMP_DIV, 4, clock cycles per ±1 power step (>=1).
- DEAD_CYCLES, 8, cycles held at power 0 before a mode flip (>=1).
- MAX_POWER, 8, saturation limit for the target power.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  target strobe; cfg_power/cfg_mode are sampled on any edge where it is high. Last write wins; no back-pressure.
- cfg_power  in  4  requested power 0..15; clamped to MAX_POWER when latched.
- cfg_mode  in  1  requested mode, heat=1, cool=0.
- act_power  out 4  registered actuator power.
- act_mode  out 1  registered actuator mode.
- busy  out 1  high whenever state != HOLD.
- settled  out 1  one-cycle pulse on the edge that returns to HOLD after a transition.

Behaviour:
- Reset (rst=1 at an edge):
  - act_power=0, act_mode=0, tgt_power=0, tgt_mode=0.
  - state=HOLD, settled=0, divider=0, dead counter=0.
  - cfg_valid is ignored while rst=1.
  - Reset mid-ramp or mid-dead-time aborts immediately. No ramp-down.
- Target register: on an edge with cfg_valid=1, tgt_power=min(cfg_power, MAX_POWER) and tgt_mode=cfg_mode. The FSM sees the new value from the next cycle.
- goal (combinational) = 0 if tgt_mode != act_mode, else tgt_power.
- HOLD:
  - If act_power != goal: go to RAMP, divider=0.
  - Else if tgt_mode != act_mode (implies act_power=0): go to DEAD, dead counter=0.
  - Else remain in HOLD.
- RAMP:
  - Divider counts 0..RAMP_DIV-1.
  - On the edge where divider==RAMP_DIV-1: act_power moves ±1 toward goal and divider returns to 0.
  - The first step lands RAMP_DIV edges after entering RAMP.
  - A retarget during RAMP changes direction at the next step. The divider is not restarted.
  - In any cycle where act_power==goal:
    - If modes are equal: go to HOLD, settled=1 for one cycle.
    - Else: go to DEAD, dead counter=0.
  - Steps never overshoot goal, and act_power never leaves 0..MAX_POWER.
- DEAD:
  - act_power stays 0. Dead counter increments each cycle.
  - If tgt_mode == act_mode (request reverted), this is an abort:
    - The next edge leaves DEAD with act_mode unchanged.
    - Go to RAMP if tgt_power != 0; else go to HOLD with settled.
  - On the edge where dead counter==DEAD_CYCLES-1:
    - act_mode=tgt_mode.
    - Go to RAMP (divider=0) if tgt_power != 0; else go to HOLD with settled.
- act_power and act_mode never change on the same edge.
- act_mode changes only while act_power=0, and only after DEAD_CYCLES full cycles at 0.
- Simultaneous cfg_valid and step on the same edge: the step uses the old goal.
- busy falls on the same edge that settled rises.
- A cfg_valid equal to the current state in HOLD produces no busy and no settled.

Test Plan (RAMP_DIV=4, DEAD_CYCLES=8, cfg written at edge E):
- Reset: drive rst for 2 cycles with cfg_valid=1, power=5 -> act_power=0, act_mode=0, busy=0, settled=0; no ramp after release.
- Ramp up: from 0/cool, cfg power=3 mode=0 -> busy rises at E+1; act_power=1,2,3 at E+5,E+9,E+13; settled pulse and busy fall at E+14.
- Mode change: from 3/cool, cfg power=2 mode=1 -> act_power 2,1,0 at E+5,E+9,E+13; DEAD entered at E+14; act_mode=1 at E+22; act_power 1,2 at E+26,E+30; settled at E+31.
- Dead-time abort: as in the mode-change case, but cfg power=2 mode=0 at E+16 -> act_mode stays 0; RAMP at E+17; act_power 1,2 at E+21,E+25; settled at E+26.
- Clamp and reversal:
  - cfg power=12 -> act_power reaches 8 at E+33 and never exceeds 8.
  - Mid-ramp at act_power=5, cfg power=2 -> next step goes to 4, settles at 2 with no overshoot.
- Reset mid-operation: assert rst while act_power=5, ramping -> act_power=0, state HOLD, busy=0 on the next edge, no settled pulse.
